// File: rtl/rr_mux_n_to_1_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_mux_n_to_1_pkg : mode encodings and clog2 helper for the RR word mux
// Revision: 1.0
// ----------------------------------------------------------------------------
package rr_mux_n_to_1_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_mux_n_to_1_priority_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_priority_pick : combinational rotating-priority encoder (first req at/after ptr)
// Revision: 1.0
// ----------------------------------------------------------------------------
module rr_priority_pick
   import rr_mux_n_to_1_pkg::*;
#(
   parameter  int NCH  = 16,
   localparam int SELW = clog2(NCH)
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   output logic [SELW-1:0] gnt_idx,
   output logic            gnt_any
);

   logic [2*NCH-1:0] w_dbl;
   logic [2*NCH-1:0] w_masked;

   // Lower copy is masked below ptr; the upper copy supplies the wrap-around.
   always_comb begin
      w_dbl = {req, req};
      for (int j = 0; j < 2*NCH; j++) begin
         w_masked[j] = w_dbl[j] && (j >= int'(ptr));
      end
      gnt_any = |req;
      gnt_idx = '0;
      for (int j = 2*NCH-1; j >= 0; j--) begin
         if (w_masked[j]) begin
            gnt_idx = (j >= NCH) ? SELW'(j - NCH) : SELW'(j);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/rr_mux_n_to_1.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_mux_n_to_1 : N-to-1 registered word mux, fixed or round-robin select, valid/ready
// Revision: 1.0
// ----------------------------------------------------------------------------
module rr_mux_n_to_1
   import rr_mux_n_to_1_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int NCH   = 16,
   localparam int SELW  = clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   input  logic [NCH-1:0]       in_valid,
   input  logic [NCH*WIDTH-1:0] in_data,
   output logic [NCH-1:0]       in_ready,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_ch,
   input  logic                 out_ready
);

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [SELW-1:0]  r_out_ch;
   logic [SELW-1:0]  r_ptr;

   logic             w_load;
   logic             w_fixed_any;
   logic [SELW-1:0]  w_rr_idx;
   logic             w_rr_any;
   logic [SELW-1:0]  w_grant;
   logic             w_grant_any;
   logic [WIDTH-1:0] w_grant_data;

   rr_priority_pick #(
      .NCH (NCH)
   ) u_pick (
      .req     (in_valid),
      .ptr     (r_ptr),
      .gnt_idx (w_rr_idx),
      .gnt_any (w_rr_any)
   );

   // A sel value at or beyond NCH matches no channel and therefore never grants.
   always_comb begin
      w_load      = !r_out_valid || out_ready;
      w_fixed_any = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (sel == SELW'(i) && in_valid[i]) begin
            w_fixed_any = 1'b1;
         end
      end

      if (mode == MODE_FIXED) begin
         w_grant     = sel;
         w_grant_any = w_fixed_any;
      end else begin
         w_grant     = w_rr_idx;
         w_grant_any = w_rr_any;
      end

      w_grant_data = '0;
      in_ready     = '0;
      for (int i = 0; i < NCH; i++) begin
         if (w_grant == SELW'(i)) begin
            w_grant_data = in_data[i*WIDTH +: WIDTH];
         end
         in_ready[i] = w_load && w_grant_any && (w_grant == SELW'(i)) && !rst;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_ptr       <= '0;
      end else if (w_load) begin
         if (w_grant_any) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_grant_data;
            r_out_ch    <= w_grant;
            if (mode == MODE_RR) begin
               r_ptr <= (w_grant == SELW'(NCH-1)) ? '0 : w_grant + 1'b1;
            end
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_ch    = r_out_ch;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_n_to_1.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rr_mux_n_to_1 : directed table vectors, corner sequences and random scoreboard
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_rr_mux_n_to_1;

   logic          clk;
   logic          rst;

   logic          mode;
   logic [3:0]    sel;
   logic [15:0]   in_valid;
   logic [511:0]  in_data;
   logic [15:0]   in_ready;
   logic          out_valid;
   logic [31:0]   out_data;
   logic [3:0]    out_ch;
   logic          out_ready;

   logic          mode3;
   logic [1:0]    sel3;
   logic [2:0]    in_valid3;
   logic [23:0]   in_data3;
   logic [2:0]    in_ready3;
   logic          out_valid3;
   logic [7:0]    out_data3;
   logic [1:0]    out_ch3;
   logic          out_ready3;

   int checks;
   int errors;

   typedef struct {
      logic [3:0]  sel;
      logic [15:0] valid;
      logic [15:0] exp_ready;
      logic        exp_ovalid;
      logic [3:0]  exp_och;
   } fvec_t;

   typedef struct {
      logic [3:0]  ch;
      logic [31:0] d;
   } word_t;

   fvec_t fv[6];
   word_t sb_q[$];

   rr_mux_n_to_1 #(.WIDTH(32), .NCH(16)) dut16 (
      .clk (clk), .rst (rst), .mode (mode), .sel (sel),
      .in_valid (in_valid), .in_data (in_data), .in_ready (in_ready),
      .out_valid (out_valid), .out_data (out_data), .out_ch (out_ch),
      .out_ready (out_ready)
   );

   rr_mux_n_to_1 #(.WIDTH(8), .NCH(3)) dut3 (
      .clk (clk), .rst (rst), .mode (mode3), .sel (sel3),
      .in_valid (in_valid3), .in_data (in_data3), .in_ready (in_ready3),
      .out_valid (out_valid3), .out_data (out_data3), .out_ch (out_ch3),
      .out_ready (out_ready3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input int i);
      return (i == 5) ? 32'hDEADBEEF : (32'hA000_0000 | 32'(i));
   endfunction

   function automatic int rr_pick(input logic [15:0] v, input int p);
      for (int k = 0; k < 16; k++) begin
         if (v[(p + k) % 16]) return (p + k) % 16;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int    m_ptr;
      logic  m_valid;
      logic  load;
      int    g;
      logic [15:0] exp_rdy;
      word_t w;
      int    rr_seq[6];
      logic [2:0] rr3_rdy[4];

      checks = 0;
      errors = 0;

      fv[0] = '{4'd5,  16'h0020, 16'h0020, 1'b1, 4'd5};
      fv[1] = '{4'd5,  16'hFFDF, 16'h0000, 1'b0, 4'd5};
      fv[2] = '{4'd0,  16'hFFFF, 16'h0001, 1'b1, 4'd0};
      fv[3] = '{4'd15, 16'h8000, 16'h8000, 1'b1, 4'd15};
      fv[4] = '{4'd7,  16'h0000, 16'h0000, 1'b0, 4'd15};
      fv[5] = '{4'd3,  16'h0008, 16'h0008, 1'b1, 4'd3};
      rr_seq = '{0, 2, 15, 0, 2, 15};
      rr3_rdy = '{3'b001, 3'b010, 3'b100, 3'b001};

      rst = 1'b1; mode = 1'b1; sel = '0; in_valid = 16'hFFFF; out_ready = 1'b1;
      for (int i = 0; i < 16; i++) in_data[i*32 +: 32] = pat(i);
      mode3 = 1'b1; sel3 = '0; in_valid3 = '0; out_ready3 = 1'b1;
      for (int i = 0; i < 3; i++) in_data3[i*8 +: 8] = 8'h30 + 8'(i);

      // Reset state
      tick; tick;
      chk("rst_in_ready", 64'(in_ready), 64'h0);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_data", 64'(out_data), 64'h0);
      chk("rst_out_ch", 64'(out_ch), 64'h0);
      rst = 1'b0;
      #1 chk("post_rst_ready", 64'(in_ready), 64'h0001);
      tick;
      chk("post_rst_och", 64'(out_ch), 64'h0);
      chk("post_rst_ovalid", 64'(out_valid), 64'h1);

      // Fixed-mode table (RR pointer is now 1)
      mode = 1'b0;
      for (int v = 0; v < 6; v++) begin
         sel = fv[v].sel;
         in_valid = fv[v].valid;
         #1 chk($sformatf("fix%0d_ready", v), 64'(in_ready), 64'(fv[v].exp_ready));
         tick;
         chk($sformatf("fix%0d_ovalid", v), 64'(out_valid), 64'(fv[v].exp_ovalid));
         chk($sformatf("fix%0d_och", v), 64'(out_ch), 64'(fv[v].exp_och));
         chk($sformatf("fix%0d_odata", v), 64'(out_data), 64'(pat(int'(fv[v].exp_och))));
      end

      // Back to RR: ptr stayed at 1, so channel 3 wins over 4 and 0
      mode = 1'b1; in_valid = 16'h0019;
      #1 chk("rr_resume_ready", 64'(in_ready), 64'h0008);
      tick;
      chk("rr_resume_och", 64'(out_ch), 64'd3);

      // Reset while holding a word under backpressure
      out_ready = 1'b0; in_valid = 16'hFFFF;
      #1 chk("hold_pre_rst_ready", 64'(in_ready), 64'h0);
      tick;
      rst = 1'b1;
      #1 chk("midrst_ready", 64'(in_ready), 64'h0);
      tick;
      rst = 1'b0;
      chk("midrst_ovalid", 64'(out_valid), 64'h0);
      chk("midrst_odata", 64'(out_data), 64'h0);

      // RR fairness over 0x8005 from ptr 0
      out_ready = 1'b1; in_valid = 16'h8005;
      for (int k = 0; k < 6; k++) begin
         #1 chk($sformatf("rr%0d_ready", k), 64'(in_ready), 64'(16'(1) << rr_seq[k]));
         tick;
         chk($sformatf("rr%0d_och", k), 64'(out_ch), 64'(rr_seq[k]));
         chk($sformatf("rr%0d_odata", k), 64'(out_data), 64'(pat(rr_seq[k])));
      end

      // Backpressure: hold for 3 cycles, then reload with no bubble
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1 chk("bp_ready", 64'(in_ready), 64'h0);
         tick;
         chk("bp_ovalid", 64'(out_valid), 64'h1);
         chk("bp_och", 64'(out_ch), 64'd15);
         chk("bp_odata", 64'(out_data), 64'(pat(15)));
      end
      out_ready = 1'b1;
      #1 chk("bp_release_ready", 64'(in_ready), 64'h0001);
      tick;
      chk("bp_release_och", 64'(out_ch), 64'd0);

      // Drain
      in_valid = 16'h0000;
      #1 chk("drain_ready", 64'(in_ready), 64'h0);
      tick;
      chk("drain_ovalid", 64'(out_valid), 64'h0);
      chk("drain_och", 64'(out_ch), 64'd0);

      // Single requester, granted every cycle regardless of ptr
      in_valid = 16'h0010;
      for (int k = 0; k < 3; k++) begin
         #1 chk("single_ready", 64'(in_ready), 64'h0010);
         tick;
         chk("single_och", 64'(out_ch), 64'd4);
      end
      in_valid = 16'h0000;

      // NCH=3, WIDTH=8: RR order 0,1,2,0 then out-of-range sel
      in_valid3 = 3'b111;
      for (int k = 0; k < 4; k++) begin
         #1 chk($sformatf("n3_rr%0d_ready", k), 64'(in_ready3), 64'(rr3_rdy[k]));
         tick;
         chk($sformatf("n3_rr%0d_och", k), 64'(out_ch3), 64'(k % 3));
         chk($sformatf("n3_rr%0d_odata", k), 64'(out_data3), 64'(8'h30 + 8'(k % 3)));
      end
      mode3 = 1'b0; sel3 = 2'd3;
      #1 chk("n3_sel3_ready", 64'(in_ready3), 64'h0);
      tick;
      chk("n3_sel3_ovalid", 64'(out_valid3), 64'h0);
      sel3 = 2'd2;
      #1 chk("n3_sel2_ready", 64'(in_ready3), 64'h4);
      tick;
      chk("n3_sel2_och", 64'(out_ch3), 64'd2);
      in_valid3 = '0;

      // Random RR traffic against a reference model and in-order scoreboard
      rst = 1'b1; tick; rst = 1'b0;
      mode = 1'b1;
      m_ptr = 0; m_valid = 1'b0;
      for (int c = 0; c < 200; c++) begin
         in_valid  = 16'($urandom) & 16'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 16; i++) in_data[i*32 +: 32] = $urandom;
         #1;
         load = !m_valid || out_ready;
         g = rr_pick(in_valid, m_ptr);
         exp_rdy = (load && g >= 0) ? (16'(1) << g) : 16'h0;
         chk("rand_ready", 64'(in_ready), 64'(exp_rdy));
         chk("rand_ovalid", 64'(out_valid), 64'(m_valid));
         if (m_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("rand_sb_empty", 64'(sb_q.size()), 64'h1);
            end else begin
               w = sb_q.pop_front();
               chk("rand_och", 64'(out_ch), 64'(w.ch));
               chk("rand_odata", 64'(out_data), 64'(w.d));
            end
         end
         if (load) begin
            if (g >= 0) begin
               sb_q.push_back('{4'(g), in_data[g*32 +: 32]});
               m_valid = 1'b1;
               m_ptr = (g == 15) ? 0 : g + 1;
            end else begin
               m_valid = 1'b0;
            end
         end
         tick;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
